// File: rtl/div3_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : div3_rr_sched
//  Description : Round-robin scheduler sharing one chunk-serial mod-3 engine
//                among REQ_N requesters. The granted word is reduced mod 3,
//                CHUNK_W bits per cycle, MSB chunk first, and the result
//                (requester id, divisible flag, remainder) is offered on a
//                valid/ready output channel.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                req_valid/ready - per-requester handshake (one-hot ready)
//                req_data        - packed operands, requester i at [i*DATA_W +: DATA_W]
//                res_valid/ready - result handshake
//                res_id/div/rem  - result fields, stable while res_valid
//                busy            - high whenever not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module div3_rr_sched #(
    parameter  int DATA_W  = 8,
    parameter  int CHUNK_W = 2,
    parameter  int REQ_N   = 4,
    localparam int ID_W    = $clog2(REQ_N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQ_N-1:0]          req_valid,
    input  logic [REQ_N*DATA_W-1:0]   req_data,
    output logic [REQ_N-1:0]          req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ID_W-1:0]           res_id,
    output logic                      res_div,
    output logic [1:0]                res_rem,
    output logic                      busy
);

    localparam int c_STEPS = DATA_W / CHUNK_W;
    localparam int c_CNT_W = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_STEPS - 1);
    // 2^CHUNK_W mod 3: weight applied to the running remainder per step
    localparam logic [1:0] c_MULT = ((CHUNK_W % 2) == 0) ? 2'd1 : 2'd2;
    localparam logic [CHUNK_W+1:0] c_THREE = (CHUNK_W + 2)'(3);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_shift;
    logic [1:0]          r_rem;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_div;
    logic [1:0]          r_res_rem;

    logic                w_grant_vld;
    logic [ID_W-1:0]     w_grant_idx;
    logic [DATA_W-1:0]   w_sel_data;
    logic [CHUNK_W-1:0]  w_chunk;
    logic [1:0]          w_chunk_mod;
    logic [2:0]          w_scaled;
    logic [3:0]          w_sum;
    logic [1:0]          w_rem_next;
    logic                w_accept;

    // Search ptr, ptr+1, ... with wrap. Scanning from the far end lets the
    // nearest valid requester overwrite any later match.
    always_comb begin
        int j;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        j = 0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= REQ_N) begin
                j = j - REQ_N;
            end
            if (req_valid[ID_W'(j)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = ID_W'(j);
            end
        end
    end

    assign w_accept   = (r_state == c_IDLE) && w_grant_vld;
    assign w_sel_data = req_data[int'(w_grant_idx) * DATA_W +: DATA_W];

    always_comb begin
        req_ready = '0;
        if (!rst && w_accept) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    // Reduce the chunk first so every intermediate stays within 0..6.
    assign w_chunk     = r_shift[DATA_W-1 -: CHUNK_W];
    assign w_chunk_mod = 2'({2'b00, w_chunk} % c_THREE);
    assign w_scaled    = (c_MULT == 2'd1) ? {1'b0, r_rem} : {r_rem, 1'b0};
    assign w_sum       = {1'b0, w_scaled} + {2'b00, w_chunk_mod};
    assign w_rem_next  = 2'(w_sum % 4'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_shift   <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_res_rem <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant_vld) begin
                        r_shift <= w_sel_data;
                        r_id    <= w_grant_idx;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_ptr   <= (int'(w_grant_idx) == REQ_N - 1) ? '0 : w_grant_idx + 1'b1;
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    r_shift <= r_shift << CHUNK_W;
                    r_rem   <= w_rem_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_res_rem <= w_rem_next;
                        r_div     <= (w_rem_next == 2'd0);
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (res_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign res_valid = (r_state == c_DONE);
    assign res_id    = r_id;
    assign res_div   = r_div;
    assign res_rem   = r_res_rem;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div3_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div3_rr_sched
//  Description : Self-checking bench for div3_rr_sched. A round-robin model
//                (pointer + modular search) and operand % 3 give expected
//                grants and results; directed and random transactions follow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div3_rr_sched;

    localparam int DATA_W  = 8;
    localparam int CHUNK_W = 2;
    localparam int REQ_N   = 4;
    localparam int ID_W    = 2;
    localparam int STEPS   = DATA_W / CHUNK_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [REQ_N-1:0]        req_valid;
    logic [REQ_N*DATA_W-1:0] req_data;
    logic [REQ_N-1:0]        req_ready;
    logic                    res_valid;
    logic                    res_ready;
    logic [ID_W-1:0]         res_id;
    logic                    res_div;
    logic [1:0]              res_rem;
    logic                    busy;

    div3_rr_sched #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .REQ_N(REQ_N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_div(res_div), .res_rem(res_rem),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    logic [7:0] data [REQ_N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive();
        req_data = {data[3], data[2], data[1], data[0]};
        #1;
    endtask

    function automatic int model_grant(input logic [REQ_N-1:0] v);
        int idx;
        for (int k = 0; k < REQ_N; k++) begin
            idx = (m_ptr + k) % REQ_N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // One complete operation: grant, STEPS busy cycles, result, optional
    // backpressure, handshake. Inputs must already be driven and settled.
    task automatic txn(input bit rr_high, input int hold, input bit immediate,
                       output int g, output logic [1:0] got_rem);
        int t, ge;
        logic [7:0] op;
        logic [1:0] er;
        logic [ID_W-1:0] id0;
        logic div0;
        logic [1:0] rem0;
        g = -1;
        got_rem = 2'bxx;
        res_ready = rr_high;
        t = 0;
        while (req_ready == '0 && t < 16) begin
            tick();
            t++;
        end
        ge = model_grant(req_valid);
        if (req_ready == '0 || ge < 0) begin
            check("grant_timeout", {28'd0, req_ready}, 32'd1 << ge);
            return;
        end
        check("grant_onehot", {28'd0, req_ready}, 32'd1 << ge);
        if (immediate) check("grant_latency", t, 0);
        g  = ge;
        op = data[ge];
        er = 2'(op % 8'd3);
        m_ptr = (ge + 1) % REQ_N;
        for (int s = 1; s <= STEPS; s++) begin
            tick();
            check("busy_high", {31'd0, busy}, 1);
            check("busy_no_result", {31'd0, res_valid}, 0);
            check("busy_no_ready", {28'd0, req_ready}, 0);
        end
        tick();
        check("res_valid", {31'd0, res_valid}, 1);
        check("res_id", {30'd0, res_id}, ge);
        check("res_rem", {30'd0, res_rem}, {30'd0, er});
        check("res_div", {31'd0, res_div}, (er == 2'd0) ? 1 : 0);
        check("done_busy", {31'd0, busy}, 1);
        got_rem = res_rem;
        if (!rr_high) begin
            id0 = res_id; div0 = res_div; rem0 = res_rem;
            for (int h = 0; h < hold; h++) begin
                tick();
                check("bp_valid", {31'd0, res_valid}, 1);
                check("bp_id", {30'd0, res_id}, ge);
                check("bp_rem", {30'd0, res_rem}, {30'd0, er});
                check("bp_div", {31'd0, res_div}, {31'd0, div0});
                check("bp_stable", {29'd0, id0, rem0} ^ {29'd0, res_id, res_rem}, 0);
                check("bp_no_ready", {28'd0, req_ready}, 0);
            end
            res_ready = 1'b1;
        end
        tick();
        check("hs_valid_drop", {31'd0, res_valid}, 0);
        check("hs_idle", {31'd0, busy}, 0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        m_ptr = 0;
    endtask

    initial begin
        int g;
        logic [1:0] r;
        logic [REQ_N-1:0] mask;
        int fair_order [5] = '{0, 1, 2, 3, 0};
        int fair_rem   [5] = '{0, 1, 2, 0, 0};
        int spot_val   [4] = '{255, 100, 2, 0};
        int spot_rem   [4] = '{0, 1, 2, 0};

        // Reset state, with all requesters valid to prove ready stays low.
        rst = 1'b1;
        res_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < REQ_N; i++) data[i] = 8'($urandom);
        drive();
        tick();
        tick();
        check("rst_req_ready", {28'd0, req_ready}, 0);
        check("rst_res_valid", {31'd0, res_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_res_id", {30'd0, res_id}, 0);
        check("rst_res_div", {31'd0, res_div}, 0);
        check("rst_res_rem", {30'd0, res_rem}, 0);
        rst = 1'b0;
        req_valid = '0;
        drive();
        tick();
        check("idle_no_valid", {28'd0, req_ready}, 0);
        m_ptr = 0;

        // Single request: 9 from requester 0.
        data[0] = 8'd9;
        req_valid = 4'b0001;
        drive();
        txn(1'b1, 0, 1'b1, g, r);
        check("single_id", g, 0);
        check("single_rem", {30'd0, r}, 0);
        req_valid = '0;
        drive();

        // Fairness from ptr=0 with everyone valid.
        reset_pulse();
        data[0] = 8'd3; data[1] = 8'd4; data[2] = 8'd5; data[3] = 8'd6;
        req_valid = 4'b1111;
        drive();
        for (int k = 0; k < 5; k++) begin
            txn(1'b1, 0, 1'b1, g, r);
            check("fair_order", g, fair_order[k]);
            check("fair_rem", {30'd0, r}, fair_rem[k]);
        end
        req_valid = '0;
        drive();

        // Backpressure for 10 cycles.
        data[0] = 8'($urandom);
        req_valid = 4'b0001;
        drive();
        txn(1'b0, 10, 1'b1, g, r);
        req_valid = '0;
        drive();

        // Pointer wrap: grant 3, then only 2 is requested.
        req_valid = 4'b1000;
        drive();
        txn(1'b1, 0, 1'b1, g, r);
        check("wrap_first", g, 3);
        req_valid = 4'b0100;
        drive();
        txn(1'b1, 0, 1'b1, g, r);
        check("wrap_second", g, 2);
        // From ptr=0, requesters 0 and 2 compete.
        req_valid = 4'b1000;
        drive();
        txn(1'b1, 0, 1'b1, g, r);
        req_valid = 4'b0101;
        drive();
        txn(1'b1, 0, 1'b1, g, r);
        check("wrap_pick0", g, 0);

        // Full operand sweep on requester 1.
        req_valid = 4'b0010;
        for (int v = 0; v < 256; v++) begin
            data[1] = 8'(v);
            drive();
            txn(1'b1, 0, 1'b1, g, r);
        end
        for (int s = 0; s < 4; s++) begin
            data[1] = 8'(spot_val[s]);
            drive();
            txn(1'b1, 0, 1'b1, g, r);
            check("spot_rem", {30'd0, r}, spot_rem[s]);
        end
        req_valid = '0;
        drive();

        // Reset in the second busy cycle of an operation from requester 2.
        data[2] = 8'($urandom);
        req_valid = 4'b0100;
        drive();
        check("abort_grant", {28'd0, req_ready}, 32'd1 << model_grant(req_valid));
        tick();
        tick();
        rst = 1'b1;
        req_valid = '0;
        drive();
        check("abort_rst_ready", {28'd0, req_ready}, 0);
        tick();
        rst = 1'b0;
        #1;
        m_ptr = 0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_valid", {31'd0, res_valid}, 0);
        mask = '0;
        for (int c = 0; c < STEPS + 4; c++) begin
            tick();
            mask = mask | {3'd0, res_valid};
        end
        check("abort_no_result", {28'd0, mask}, 0);
        // ptr must be 0 again: 1 wins over 3 only if the search starts at 0.
        data[1] = 8'($urandom);
        data[3] = 8'($urandom);
        req_valid = 4'b1010;
        drive();
        txn(1'b0, 2, 1'b1, g, r);
        check("post_reset_grant", g, 1);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < REQ_N; i++) begin
                if (!req_valid[i] || i == g) data[i] = 8'($urandom);
            end
            req_valid = mask;
            drive();
            txn(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1, g, r);
        end
        req_valid = '0;
        drive();
        tick();
        check("final_idle", {31'd0, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div3_rr_sched.md
Name: div3_rr_sched

Overview:
- Round-robin scheduler that shares one bit-serial divisibility-by-3 engine among REQ_N requesters.
- Each requester offers a DATA_W-bit word over a valid/ready handshake.
- The granted word is reduced mod 3 at CHUNK_W bits per cycle.
- One result (requester id, divisible flag, remainder) is returned over a valid/ready output channel.

Parameters:
- DATA_W, 8, operand width; must be a multiple of CHUNK_W.
- CHUNK_W, 2, bits consumed per engine cycle (1..DATA_W).
- REQ_N, 4, number of requesters (>=2).
- Derived: STEPS = DATA_W/CHUNK_W; ID_W = $clog2(REQ_N).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  REQ_N  per-requester operand valid.
- req_data  in  REQ_N*DATA_W  packed operands; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  REQ_N  per-requester accept; at most one bit high.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_id  out  ID_W  index of the requester whose word produced the result.
- res_div  out  1  1 when operand mod 3 == 0.
- res_rem  out  2  operand mod 3 (0..2).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset state: IDLE; rr pointer=0; res_valid=0; res_id=0; res_div=0; res_rem=0; busy=0; req_ready=0 while rst is high.
- Reset wins over every other event. Reset in BUSY or DONE aborts the operation silently; no result is ever emitted for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE, grant selection:
  - Combinationally pick g = first i with req_valid[i], searching ptr, ptr+1, ... with wrap mod REQ_N.
  - Drive req_ready[g]=1; all other req_ready bits are 0.
  - With no req_valid set, all req_ready=0 and the state stays IDLE.
- IDLE, acceptance edge:
  - Latch req_data slice g into the shift register and g into the id register.
  - Set rem=0, step count=0, ptr=(g+1) mod REQ_N; go to BUSY.
- req_ready is 0 in BUSY and DONE: one operation in flight, no input buffering.
- BUSY, per cycle:
  - Consume the next CHUNK_W bits, MSB chunk first.
  - Update rem = (rem*2^CHUNK_W + chunk) mod 3. 2^CHUNK_W mod 3 is 1 for even CHUNK_W and 2 for odd.
  - rem stays in 0..2; intermediate sums are sized so they never overflow.
  - After STEPS cycles, go to DONE with res_rem=rem and res_div=(rem==0).
- Latency: operand accepted at edge of cycle T; BUSY occupies cycles T+1..T+STEPS; res_valid is high from cycle T+STEPS+1. Default: 5 cycles.
- DONE:
  - res_valid=1; res_id, res_div and res_rem are held stable until res_ready=1.
  - On handshake, go to IDLE and drop res_valid the next cycle.
  - No input is accepted in the handshake cycle. Minimum spacing between acceptances is STEPS+2 cycles.
- Outside DONE, res_valid=0. res_* hold their last values and are don't-care for checking.
- Requesters must hold data stable while valid and not yet ready. Dropping valid before grant is legal, and the grant re-evaluates every IDLE cycle.
- Operand 0 gives res_div=1, res_rem=0.
- Pointer wrap: grant at index REQ_N-1 sets ptr=0.

Test Plan:
- Single request: only requester 0 valid with 8'd9 -> req_ready[0]=1 in the acceptance cycle T; res_valid rises at T+5 with res_id=0, res_div=1, res_rem=0; busy=1 during T+1..T+5.
- Value sweep on requester 1, res_ready tied high:
  - all operands 0..255 -> res_rem == operand%3 and res_div == (operand%3==0) for each;
  - spot checks: 255->div=1, rem=0; 100->rem=1; 8'd2->rem=2; 0->div=1.
- Fairness: all 4 requesters valid continuously (data 3,4,5,6), res_ready high -> grant order 0,1,2,3,0 with rems 0,1,2,0,0; each grant follows the previous result handshake by exactly 1 cycle.
- Backpressure: hold res_ready=0 for 10 cycles once res_valid rises -> res_valid, res_id, res_div, res_rem are stable; req_ready=0 throughout; raising res_ready drains one result and returns to IDLE.
- Pointer wrap: grant requester 3 first, then assert only requester 2 -> requester 2 is granted (search wraps 0,1,2).
- Same pointer state with requesters 0 and 2 both valid -> requester 0 is granted.
- Reset mid-op: assert rst for 1 cycle in the second BUSY cycle -> next cycle state is IDLE, busy=0, res_valid=0, ptr=0; no result is ever produced for the aborted word; a following request from requester 1 completes normally.
